// File: rtl/bitcount_pkg.sv
// Shared widths and feeder state encoding for the bit-count datapath.
// Both the feeder and the bit-count stage import these so the word/result widths cannot drift.
package bitcount_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/bitcount_feeder_if.sv
// Push-side and bit-count-stage signals of the feeder, bundled for port connection.
// master = the feeder itself, slave = the board/test side plus the bit-count stage.
interface bitcount_feeder_if
    import bitcount_pkg::*;
#(
    parameter int TOT_W = 12,
    parameter int CNT_W = 8
);

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              empty;
    logic              overflow;

    logic              cnt_start;
    logic [DATA_W-1:0] cnt_input;
    logic              cnt_ready;
    logic              cnt_done;
    logic [RES_W-1:0]  cnt_result;

    logic [RES_W-1:0]  last_result;
    logic [TOT_W-1:0]  total;
    logic [CNT_W-1:0]  words_done;
    logic              busy;

    modport master (
        input  push, push_data, cnt_ready, cnt_done, cnt_result,
        output full, empty, overflow, cnt_start, cnt_input,
               last_result, total, words_done, busy
    );

    modport slave (
        output push, push_data, cnt_ready, cnt_done, cnt_result,
        input  full, empty, overflow, cnt_start, cnt_input,
               last_result, total, words_done, busy
    );

endinterface

// File: rtl/bitcount_fifo.sv
// Small circular word buffer between the push side and the feeder FSM.
// Head word is presented combinationally so a pop can capture it on the same edge.
module bitcount_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_overflow;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
    assign w_do_push = i_push && ((r_count != CNT_FULL) || w_do_pop);

    assign o_head     = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CNT_FULL);
    assign o_empty    = (r_count == '0);
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitcount_feeder.sv
// Feeds buffered words to the bit-count stage over Start/Ready/Done and keeps
// running statistics (last result, saturating ones total, words processed).
module bitcount_feeder
    import bitcount_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TOT_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                Reset_n,
    bitcount_feeder_if.master   bus
);

    feeder_state_t     r_state;
    logic              r_cnt_start;
    logic [DATA_W-1:0] r_cnt_input;
    logic [RES_W-1:0]  r_last_result;
    logic [TOT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_words_done;

    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_overflow;
    logic [TOT_W:0]    w_sum;

    bitcount_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .i_push      (bus.push),
        .i_push_data (bus.push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_overflow  (w_overflow)
    );

    assign w_pop = (r_state == IDLE) && !w_empty && bus.cnt_ready;
    // One extra bit catches the carry that signals saturation.
    assign w_sum = {1'b0, r_total} + {{(TOT_W + 1 - RES_W){1'b0}}, bus.cnt_result};

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_state       <= IDLE;
            r_cnt_start   <= 1'b0;
            r_cnt_input   <= '0;
            r_last_result <= '0;
            r_total       <= '0;
            r_words_done  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_cnt_input <= w_head;
                        r_cnt_start <= 1'b1;
                        r_state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt_start <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (bus.cnt_done) begin
                        r_last_result <= bus.cnt_result;
                        r_total       <= w_sum[TOT_W] ? '1 : w_sum[TOT_W-1:0];
                        r_words_done  <= r_words_done + CNT_W'(1);
                        r_state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A long Done pulse is absorbed here so it is counted once.
                    if (!bus.cnt_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt_start <= 1'b0;
                end
            endcase
        end
    end

    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.overflow    = w_overflow;
    assign bus.cnt_start   = r_cnt_start;
    assign bus.cnt_input   = r_cnt_input;
    assign bus.last_result = r_last_result;
    assign bus.total       = r_total;
    assign bus.words_done  = r_words_done;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_bitcount_feeder.sv
// Directed bench: feeder paired with a behavioural bit-count stage (fixed latency,
// Done held for a programmable number of cycles, not reset by Reset_n).
module tb_bitcount_feeder;
    import bitcount_pkg::*;

    localparam int DEPTH = 4;
    localparam int TOT_W = 12;
    localparam int CNT_W = 8;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 clk = ~clk;

    bitcount_feeder_if #(.TOT_W(TOT_W), .CNT_W(CNT_W)) bus ();

    bitcount_feeder #(
        .DEPTH (DEPTH),
        .TOT_W (TOT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural bit-count stage
    logic              stall     = 1'b0;
    int                done_hold = 1;
    logic              m_busy    = 1'b0;
    logic              m_done    = 1'b0;
    logic [RES_W-1:0]  m_res     = '0;
    logic [DATA_W-1:0] m_word    = '0;
    int                m_cnt     = 0;
    int                m_hold    = 0;

    assign bus.cnt_ready  = !m_busy && !stall;
    assign bus.cnt_done   = m_done;
    assign bus.cnt_result = m_res;

    always @(posedge clk) begin
        if (!m_busy) begin
            m_done <= 1'b0;
            if (bus.cnt_start) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_word <= bus.cnt_input;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end else if (!m_done) begin
            m_done <= 1'b1;
            m_res  <= RES_W'($countones(m_word));
            m_hold <= done_hold - 1;
        end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
        end else begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        bus.push      = 1'b1;
        bus.push_data = d;
        @(negedge clk);
        bus.push      = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        Reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        Reset_n = 1'b1;
    endtask

    task automatic wait_word(input string tag, input logic [RES_W-1:0] exp_res);
        logic [CNT_W-1:0] prev;
        int g;
        prev = bus.words_done;
        g = 0;
        while (bus.words_done == prev && g < 200) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_words_inc"}, bus.words_done, prev + CNT_W'(1));
        check({tag, "_last_result"}, bus.last_result, exp_res);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int g;
        g = 0;
        while (!(bus.empty && !bus.busy) && g < limit) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_idle_empty_busy"}, {bus.empty, bus.busy}, 2'b10);
    endtask

    initial begin
        int g;
        int n_drain;
        logic [TOT_W-1:0] t0;
        logic [CNT_W-1:0] w0;

        bus.push      = 1'b0;
        bus.push_data = '0;

        // Reset state
        apply_reset(2);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_cnt_start", bus.cnt_start, 0);
        check("rst_cnt_input", bus.cnt_input, 0);
        check("rst_last_result", bus.last_result, 0);
        check("rst_total", bus.total, 0);
        check("rst_words_done", bus.words_done, 0);
        check("rst_busy", bus.busy, 0);

        // Single word, launch latency and one-cycle Start pulse
        do_push(8'h89);
        check("lat_start_c1", bus.cnt_start, 0);
        @(negedge clk);
        check("lat_start_c2", bus.cnt_start, 1);
        check("lat_cnt_input", bus.cnt_input, 8'h89);
        @(negedge clk);
        check("lat_start_drop", bus.cnt_start, 0);
        check("lat_busy", bus.busy, 1);
        check("lat_input_held", bus.cnt_input, 8'h89);
        wait_word("w89", 4'd3);
        check("w89_total", bus.total, 3);
        wait_idle("w89", 50);

        // Fill while stalled, overflow on fifth push, then drain in order
        apply_reset(1);
        stall = 1'b1;
        do_push(8'hFF);
        do_push(8'h0F);
        do_push(8'h01);
        do_push(8'h00);
        check("fill_full", bus.full, 1);
        check("fill_overflow_pre", bus.overflow, 0);
        do_push(8'hAA);
        check("ovf_overflow", bus.overflow, 1);
        check("ovf_full", bus.full, 1);
        check("ovf_not_busy", bus.busy, 0);
        stall = 1'b0;
        wait_word("wFF", 4'd8);
        wait_word("w0F", 4'd4);
        wait_word("w01", 4'd1);
        wait_word("w00", 4'd0);
        wait_idle("drain4", 100);
        check("drain4_total", bus.total, 13);
        check("drain4_words", bus.words_done, 4);
        check("drain4_overflow_sticky", bus.overflow, 1);

        // Done held three cycles: counted once, three DRAIN cycles
        done_hold = 3;
        t0 = bus.total;
        w0 = bus.words_done;
        do_push(8'h07);
        wait_word("w07", 4'd3);
        n_drain = 0;
        while (bus.busy && n_drain < 20) begin
            n_drain++;
            @(negedge clk);
        end
        check("hold_drain_cycles", n_drain, 3);
        repeat (5) @(negedge clk);
        check("hold_words_once", bus.words_done, w0 + CNT_W'(1));
        check("hold_total", bus.total, t0 + TOT_W'(3));
        done_hold = 1;

        // Reset during WAIT discards the word and ignores the late Done
        do_push(8'hF0);
        g = 0;
        while (!bus.cnt_start && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("abort_start_seen", bus.cnt_start, 1);
        @(negedge clk);
        check("abort_in_wait", bus.busy, 1);
        apply_reset(1);
        check("abort_total", bus.total, 0);
        check("abort_words", bus.words_done, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_cnt_input", bus.cnt_input, 0);
        check("abort_overflow", bus.overflow, 0);
        repeat (10) @(negedge clk);
        check("late_done_words", bus.words_done, 0);
        check("late_done_total", bus.total, 0);
        check("late_done_last", bus.last_result, 0);
        check("late_done_busy", bus.busy, 0);

        // Saturation of total and wrap of words_done
        apply_reset(1);
        for (int k = 0; k < 512; k++) begin
            g = 0;
            while (bus.full && g < 100) begin
                @(negedge clk);
                g++;
            end
            do_push(8'hFF);
        end
        g = 0;
        while (bus.full && g < 100) begin
            @(negedge clk);
            g++;
        end
        do_push(8'h01);
        wait_idle("sat", 20000);
        check("sat_total", bus.total, 4095);
        check("sat_words_wrap", bus.words_done, 1);
        check("sat_last_result", bus.last_result, 1);
        check("sat_no_overflow", bus.overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
